// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register stage buffers.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pipe_pkg;

    // Occupancy of a stage buffer. FULL means the skid entry also holds a beat.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // Default payload width of a pipeline register (XLEN).
    localparam int PIPE_DATA_W = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; clr wins over inc, and the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Clear first, then count up until every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline register stage with valid/ready handshake, flush and stall counter.
// Latency: an accepted beat appears on out_data_o one cycle later when empty.
// Backpressure: skid build keeps in_ready_o registered (2 entries); plain build passes out_ready_i through.
// Build option: define PIPE_SKID_EN for the 2-entry skid buffer; otherwise a single register.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    buf_state_e        state;
    logic [DATA_W-1:0] main_data;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // Output side is taken straight from registers: main entry and state.
    assign out_valid_o = (state != ST_EMPTY);
    assign out_data_o  = main_data;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;
    assign stall    = out_valid_o & ~out_ready_i;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data;

    // Ready depends only on the state register, so upstream timing never
    // sees out_ready_i; the skid entry absorbs the beat in flight.
    assign in_ready_o = (state != ST_FULL);

    // Occupancy FSM: main entry drives the output, skid catches one extra beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush_i) begin
            // Flush wins over a simultaneous accept: that beat is dropped.
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data <= in_data_i;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && !out_fire) begin
                        skid_data <= in_data_i;
                        state     <= ST_FULL;
                    end else if (in_fire && out_fire) begin
                        main_data <= in_data_i;
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready_o is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_data <= skid_data;
                        state     <= ST_BUSY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end
`else
    // Accept when empty or when the held beat leaves this same cycle.
    assign in_ready_o = ~out_valid_o | out_ready_i;

    // Single register: an accept while busy always coincides with a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_data <= '0;
        end else if (flush_i) begin
            state <= ST_EMPTY;
        end else if (in_fire) begin
            main_data <= in_data_i;
            state     <= ST_BUSY;
        end else if (out_fire) begin
            state <= ST_EMPTY;
        end
    end
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_i),
        .inc   (stall),
        .cnt   (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf with a data scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_stage_buf;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          cnt_clr   = 1'b0;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .cnt_clr_i   (cnt_clr),
        .stall_cnt_o (stall_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until the stage takes it (bounded wait).
    task automatic send(input logic [63:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_accept", 64'(in_ready), 64'd1);
    endtask

    // Scoreboard: push on accept, pop on delivery, flush/reset empty it.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_vld", 64'(out_valid), 64'd1);
                check_val("hold_dat", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check_val("sb_data", out_data, exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while held in reset.
        @(negedge clk);
        @(negedge clk);
        check_val("rst_vld", 64'(out_valid), 64'd0);
        check_val("rst_dat", out_data, 64'd0);
        check_val("rst_cnt", 64'(stall_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rdy", 64'(in_ready), 64'd1);

        // Streaming: 8 beats back to back, one-cycle latency.
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            @(negedge clk);
            check_val("st_rdy", 64'(in_ready), 64'd1);
            if (i > 1) begin
                check_val("st_vld", 64'(out_valid), 64'd1);
                check_val("st_dat", out_data, 64'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_val("st_last_vld", 64'(out_valid), 64'd1);
        check_val("st_last_dat", out_data, 64'd8);
        check_val("st_cnt", 64'(stall_cnt), 64'd0);
        step();
        @(negedge clk);
        check_val("st_idle", 64'(out_valid), 64'd0);

        // Backpressure: A,B,C with the sink stalled for the first cycles.
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(64'hA);
                step();
                send(64'hB);
                step();
                send(64'hC);
                step();
                in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                check_val("bp_rdy_c0", 64'(in_ready), 64'd1);
                @(negedge clk);
`ifdef PIPE_SKID_EN
                check_val("bp_rdy_c1", 64'(in_ready), 64'd1);
`else
                check_val("bp_rdy_c1", 64'(in_ready), 64'd0);
`endif
                @(negedge clk);
                check_val("bp_rdy_c2", 64'(in_ready), 64'd0);
                @(negedge clk);
                check_val("bp_rdy_c3", 64'(in_ready), 64'd0);
                step();
                out_ready = 1'b1;
                @(negedge clk);
                check_val("bp_cnt", 64'(stall_cnt), 64'd3);
                check_val("bp_dat_a", out_data, 64'hA);
`ifdef PIPE_SKID_EN
                check_val("bp_rdy_c4", 64'(in_ready), 64'd0);
`else
                check_val("bp_rdy_c4", 64'(in_ready), 64'd1);
`endif
            end
        join
        repeat (4) step();
        @(negedge clk);
        check_val("bp_drain", 64'(exp_q.size()), 64'd0);
        check_val("bp_idle", 64'(out_valid), 64'd0);

        // Flush: two beats buffered, flush with a new beat offered.
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        step();
        in_data = 64'h22;
        step();
        flush   = 1'b1;
        in_data = 64'h33;
        @(negedge clk);
        check_val("fl_dat", out_data, 64'h11);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("fl_vld", 64'(out_valid), 64'd0);
        check_val("fl_cnt", 64'(stall_cnt), 64'd2);
        // Flush wins over an accept in the same cycle.
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h55;
        @(negedge clk);
        check_val("fl2_rdy", 64'(in_ready), 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("fl2_vld", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check_val("fl_q", 64'(exp_q.size()), 64'd0);

        // Counter saturation and clear priority.
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        send(64'h77);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check_val("cnt_sat", 64'(stall_cnt), 64'd15);
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check_val("cnt_clr", 64'(stall_cnt), 64'd0);
        step();
        @(negedge clk);
        check_val("cnt_resume", 64'(stall_cnt), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_val("cnt_q", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a stalled stream.
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h91;
        step();
        in_data = 64'h92;
        step();
        check_val("rst_pre_vld", 64'(out_valid), 64'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("rst_mid_vld", 64'(out_valid), 64'd0);
        check_val("rst_mid_cnt", 64'(stall_cnt), 64'd0);
        check_val("rst_mid_dat", out_data, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rel_rdy", 64'(in_ready), 64'd1);
        check_val("rst_rel_vld", 64'(out_valid), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (XLEN for the pipeline).
REQ-002 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  kill all buffered beats.
REQ-006 SHALL have port in_valid_i  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready_o  output  1  stage can accept a beat.
REQ-008 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid_o  output  1  downstream beat valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-011 SHALL have port out_data_o  output  DATA_W  downstream payload.
REQ-012 SHALL have port cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-013 SHALL have port stall_cnt_o  output  CNT_W  count of stalled cycles.

Function
REQ-014 SHALL define in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i.
REQ-015 SHALL present an accepted beat on out_data_o/out_valid_o exactly 1 cycle after in_fire when empty.
REQ-016 SHALL preserve beat order; no beat duplicated or dropped except by flush_i.
REQ-017 SHALL hold out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-018 SHALL, on flush_i=1, clear all valid state next cycle; an in_fire in the same cycle is discarded (flush wins).
REQ-019 SHALL increment stall_cnt_o each cycle with out_valid_o=1 and out_ready_i=0, saturating at all-ones.
REQ-020 SHALL give cnt_clr_i priority over increment (counter becomes 0); flush_i does not affect the counter.

Reset
REQ-021 SHALL, while rst_n=0, force out_valid_o=0, out_data_o=0, stall_cnt_o=0, state EMPTY, skid entry invalid and zeroed.
REQ-022 SHALL, on reset assertion mid-transfer, discard all beats immediately; in_ready_o=1 on first cycle after release.

Configuration
REQ-023 SHALL use macro PIPE_SKID_EN to select the buffering mode.
REQ-024 SHALL, with PIPE_SKID_EN defined, implement a 2-entry skid buffer, states EMPTY/BUSY/FULL, in_ready_o = (state != FULL) driven from a register only (no combinational path from out_ready_i).
REQ-025 SHALL, in skid mode, transition: EMPTY-in_fire->BUSY; BUSY-in_fire&!out_fire->FULL (beat to skid); BUSY-out_fire&!in_fire->EMPTY; BUSY-in_fire&out_fire->BUSY (main reloaded); FULL-out_fire->BUSY (main<=skid); any state-flush_i->EMPTY.
REQ-026 SHALL, in skid mode, sustain 1 beat/cycle when out_ready_i stays 1.
REQ-027 SHALL, without PIPE_SKID_EN, implement a single register with in_ready_o = !out_valid_o | out_ready_i (combinational), states EMPTY/BUSY only.

Structure
REQ-028 SHALL take state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and default DATA_W from shared package pipe_pkg.
REQ-029 SHALL implement the saturating stall counter as sub-module sat_counter (params CNT_W; ports clk, rst_n, clr, inc, cnt).
REQ-030 SHALL be usable unmodified as the IF/ID, ID/EX, EX/LS and LS/WB pipeline registers, with bundled fields concatenated into in_data_i.

Verification
REQ-031 SHALL test reset: rst_n=0 mid-stream with FULL state -> out_valid_o=0, stall_cnt_o=0 at once; in_ready_o=1 after release.
REQ-032 SHALL test streaming: 8 beats 0x1..0x8, out_ready_i=1 -> outputs 0x1..0x8 on 8 consecutive cycles, 1-cycle latency, stall_cnt_o=0.
REQ-033 SHALL test backpressure (skid): send 0xA,0xB,0xC, out_ready_i=0 for 3 cycles -> in_ready_o=0 after 0xB stored, 0xC held upstream, stall_cnt_o=3, then outputs 0xA,0xB,0xC in order.
REQ-034 SHALL test flush: FULL with 0x11/0x22, flush_i=1 with in_valid_i=1 data 0x33 -> next cycle out_valid_o=0, 0x33 never appears.
REQ-035 SHALL test counter: CNT_W=4, hold stall 20 cycles -> stall_cnt_o=15; cnt_clr_i=1 same cycle as stall -> 0.
REQ-036 SHALL run REQ-032..REQ-034 with PIPE_SKID_EN undefined -> same order/data; in_ready_o follows out_ready_i combinationally when BUSY.
